// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB 3-phase write master (START, 27 bits, STOP) driving sioc/siod.
// Optional macro SCCB_ACK_CHECK_EN samples siod at each ACK bit into a sticky nack flag.
module sccb_master #(
    parameter int QTR = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] id,
    input  logic [7:0] reg_addr,
    input  logic [7:0] value,
    output logic       ready,
    output logic       done,
    output logic       nack,
    output logic       sioc,
    inout  wire        siod
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_STOP} state_t;

    localparam logic [11:0] QTR_LAST = 12'(QTR - 1);

    state_t      state_q, state_d;
    logic [11:0] qcnt_q, qcnt_d;
    logic [1:0]  q_q, q_d;
    logic [4:0]  bit_q, bit_d;
    logic [3:0]  pos_q, pos_d;
    logic [23:0] shift_q, shift_d;
    logic        sioc_q, sioc_d;
    logic        sdo_q, sdo_d;
    logic        soe_q, soe_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        qtr_end;

    assign qtr_end = (qcnt_q == QTR_LAST);

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        q_d     = q_q;
        bit_d   = bit_q;
        pos_d   = pos_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                shift_d = {id, reg_addr, value};
                state_d = S_START;
                qcnt_d  = '0;
                q_d     = '0;
                bit_d   = '0;
                pos_d   = '0;
            end
        end else if (!qtr_end) begin
            qcnt_d = qcnt_q + 12'd1;
        end else begin
            qcnt_d = '0;
            q_d    = q_q + 2'd1;
            if (q_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d = S_BITS;
                        bit_d   = '0;
                        pos_d   = '0;
                    end
                    S_BITS: begin
                        // Only data bits consume the shift register; the ACK slot does not.
                        if (pos_q != 4'd8) shift_d = {shift_q[22:0], 1'b0};
                        if (bit_q == 5'd26) begin
                            state_d = S_STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            pos_d = (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end

        // Line levels are decoded from the next state so they leave flops cleanly.
        sioc_d = 1'b1;
        sdo_d  = 1'b1;
        soe_d  = 1'b1;
        case (state_d)
            S_START: begin
                sioc_d = (q_d <= 2'd1);
                sdo_d  = (q_d == 2'd0);
            end
            S_BITS: begin
                sioc_d = (q_d == 2'd1) || (q_d == 2'd2);
                sdo_d  = shift_d[23];
                soe_d  = (pos_d != 4'd8);
            end
            S_STOP: begin
                sioc_d = (q_d != 2'd0);
                sdo_d  = q_d[1];
            end
            default: ;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            pos_q   <= '0;
            shift_q <= '0;
            sioc_q  <= 1'b1;
            sdo_q   <= 1'b1;
            soe_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            pos_q   <= pos_d;
            shift_q <= shift_d;
            sioc_q  <= sioc_d;
            sdo_q   <= sdo_d;
            soe_q   <= soe_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nack_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            nack_q <= 1'b0;
        end else if (state_q == S_BITS && pos_q == 4'd8 && q_q == 2'd2 && qtr_end
                     && siod == 1'b1) begin
            nack_q <= 1'b1;
        end
    end

    assign nack = nack_q;
`else
    assign nack = 1'b0;
`endif

    assign sioc  = sioc_q;
    assign siod  = soe_q ? sdo_q : 1'bz;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sccb_master.sv
// tb/tb_sccb_master.sv - directed bench for sccb_master (QTR=2 main instance, QTR=1 side instance).
module tb_sccb_master;

    localparam int QTR = 2;
    localparam int D   = 1 + 116 * QTR;
`ifdef SCCB_ACK_CHECK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, slave_low;
    logic [7:0] id, reg_addr, value;
    logic       ready, done, nack, sioc;
    wire        siod;

    assign siod = slave_low ? 1'b0 : 1'bz;
    pullup (siod);

    sccb_master #(.QTR(QTR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .id       (id),
        .reg_addr (reg_addr),
        .value    (value),
        .ready    (ready),
        .done     (done),
        .nack     (nack),
        .sioc     (sioc),
        .siod     (siod)
    );

    logic start1, ready1, done1, nack1, sioc1;
    wire  siod1;
    pullup (siod1);

    sccb_master #(.QTR(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .id       (8'h42),
        .reg_addr (8'h12),
        .value    (8'h80),
        .ready    (ready1),
        .done     (done1),
        .nack     (nack1),
        .sioc     (sioc1),
        .siod     (siod1)
    );

    int   vecs = 0;
    int   errs = 0;
    logic cap_sioc [0:D];
    logic cap_siod [0:D];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qs(input int k);
        return 1 + k * QTR;
    endfunction

    // Slave pulls siod low across every ACK bit, except optionally the last one.
    function automatic logic ack_low(input int i, input logic rel2);
        int k, b;
        k = (i - 1) / QTR;
        if (k < 4 || k >= 112) return 1'b0;
        b = (k - 4) / 4;
        if (b % 9 != 8) return 1'b0;
        if (rel2 && b == 26) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic pre, input logic hold, input logic rel2, input logic poke,
                           input logic [7:0] n0, input logic [7:0] n1, input logic [7:0] n2);
        int         rdy_low, early_done, bad, k;
        logic [7:0] got;
        logic [7:0] exp_b [0:2];
        logic [3:0] pc, pd;
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
        if (!pre) begin
            @(negedge clk);
            chk("ready_before_start", ready, 1);
            id = b0; reg_addr = b1; value = b2; start = 1'b1;
        end
        rdy_low = 0; early_done = 0;
        for (int i = 1; i <= D; i++) begin
            @(negedge clk);
            slave_low = ack_low(i, rel2);
            if (i == 1) begin
                start = hold; id = n0; reg_addr = n1; value = n2;
            end
            if (poke && i == 60) start = 1'b1;
            if (poke && i == 61) start = 1'b0;
            if (poke && i == 150) start = 1'b1;
            if (poke && i == 151) start = 1'b0;
            #1;
            cap_sioc[i] = sioc;
            cap_siod[i] = siod;
            if (i == 1) chk("nack_cleared", nack, 0);
            if (i < D) begin
                if (!ready) rdy_low++;
                if (done) early_done++;
            end
        end
        chk("done_pulse", done, 1);
        chk("ready_at_done", ready, 1);
        chk("ready_low_cycles", rdy_low, D - 1);
        chk("done_early", early_done, 0);
        chk("nack_at_done", nack, ACK_EN & rel2);
        for (int j = 0; j < 4; j++) begin
            pc[3-j] = cap_sioc[qs(j)];
            pd[3-j] = cap_siod[qs(j)];
        end
        chk("start_sioc", pc, 4'b1100);
        chk("start_siod", pd, 4'b1000);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 8; b++) got[7-b] = cap_siod[qs(4 + 4 * (9 * p + b) + 1)];
            chk("byte", got, exp_b[p]);
            chk("ack_level", cap_siod[qs(4 + 4 * (9 * p + 8) + 1)], (rel2 && p == 2) ? 1 : 0);
        end
        bad = 0;
        for (int b = 0; b < 27; b++) begin
            for (int c = 0; c < 4 * QTR; c++) begin
                k = qs(4 + 4 * b) + c;
                if (cap_sioc[k] !== ((c / QTR == 1) || (c / QTR == 2))) bad++;
                if (cap_siod[k] !== cap_siod[qs(4 + 4 * b)]) bad++;
            end
        end
        chk("bit_shape", bad, 0);
        for (int j = 0; j < 4; j++) begin
            pc[3-j] = cap_sioc[qs(112 + j)];
            pd[3-j] = cap_siod[qs(112 + j)];
        end
        chk("stop_sioc", pc, 4'b0111);
        chk("stop_siod", pd, 4'b0011);
    endtask

    initial begin
        int cnt, lat, bad;
        logic s1 [0:117];
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; slave_low = 1'b0;
        id = 8'h00; reg_addr = 8'h00; value = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sioc", sioc, 1);
        chk("rst_siod", siod, 1);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        rst_n = 1'b1;

        run_txn(8'h42, 8'h12, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);

        run_txn(8'hA5, 8'h3C, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (!ready || done || !sioc) cnt++;
        end
        chk("no_queued_start", cnt, 0);

        run_txn(8'h5A, 8'hC3, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        run_txn(8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 8'hEE, 8'hEE);

        run_txn(8'h42, 8'h3A, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        run_txn(8'h42, 8'h3B, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        @(negedge clk);
        id = 8'h42; reg_addr = 8'h55; value = 8'hAA; start = 1'b1;
        for (int i = 1; i <= 89; i++) begin
            @(negedge clk);
            slave_low = ack_low(i, 1'b0);
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        slave_low = 1'b0;
        @(negedge clk); #1;
        chk("midrst_sioc", sioc, 1);
        chk("midrst_siod", siod, 1);
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk); #1;
            if (done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        run_txn(8'h42, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        @(negedge clk); #1;
        chk("q1_ready", ready1, 1);
        chk("q1_idle_siod", siod1, 1);
        start1 = 1'b1;
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) start1 = 1'b0;
            #1;
            if (i <= 117) s1[i] = sioc1;
            if (done1 && lat < 0) lat = i;
        end
        chk("q1_latency", lat, 117);
        bad = 0;
        for (int b = 0; b < 27; b++) begin
            cnt = 0;
            for (int c = 0; c < 4; c++) if (s1[5 + 4 * b + c]) cnt++;
            if (cnt != 2 || !s1[6 + 4 * b] || !s1[7 + 4 * b]) bad++;
        end
        chk("q1_sioc_high2", bad, 0);
        chk("q1_nack", nack1, ACK_EN);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 Parameter: QTR, default 125, clk cycles per SIOC quarter-period (50 MHz clk -> 100 kHz SIOC); legal range 1..4095.
REQ-002 clk  input  1  system clock (clk50 domain); all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request one 3-phase write; accepted only on a cycle with ready=1.
REQ-005 id  input  8  SCCB device write ID (0x42 for OV7670).
REQ-006 reg_addr  input  8  target register sub-address.
REQ-007 value  input  8  register write data.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 nack  output  1  sticky NACK flag (see Configuration).
REQ-011 sioc  output  1  SCCB clock.
REQ-012 siod  inout  1  SCCB data; driven 0/1 or released to high-Z.

Function
REQ-013 States SHALL be IDLE, START, BITS, STOP; a quarter counter (0..QTR-1), quarter index q (0..3) and bit index (0..26) SHALL sequence them.
REQ-014 IDLE: sioc=1, siod driven 1, ready=1; start=1 latches {id,reg_addr,value} into a 24-bit shift register, clears nack, enters START; ready=0 from the next cycle.
REQ-015 START, 4 quarters: q0 sioc=1 siod=1; q1 sioc=1 siod=0; q2,q3 sioc=0 siod=0.
REQ-016 BITS, 27 bits (3 phases x 9), 4 quarters each: q0 sioc=0 with data presented; q1,q2 sioc=1; q3 sioc=0; siod stable for all 4 quarters.
REQ-017 Bits 0-7 of each phase SHALL be sent MSB-first from the latched byte; bit 8 (don't-care/ACK) SHALL release siod to high-Z.
REQ-018 STOP, 4 quarters: q0 sioc=0 siod=0; q1 sioc=1 siod=0; q2,q3 sioc=1 siod=1.
REQ-019 After STOP q3 the FSM SHALL enter IDLE with done=1 and ready=1 in the same cycle; done is low in every other cycle.
REQ-020 Latency: start accepted at cycle N -> done at cycle N+1+116*QTR.
REQ-021 start while ready=0 SHALL be ignored, with no queuing; input changes after acceptance SHALL not affect the transfer.
REQ-022 start asserted in the done cycle SHALL be accepted; back-to-back transactions are legal.
REQ-023 sioc and siod-drive SHALL be registered outputs (glitch-free).

Reset
REQ-024 rst_n=0 at any edge SHALL force IDLE: sioc=1, siod driven 1, ready=1, done=0, nack=0, counters=0.
REQ-025 Reset mid-transaction SHALL abort with no done pulse; the next start after release begins a full transaction.

Configuration
REQ-026 Macro SCCB_ACK_CHECK_EN: when defined, siod SHALL be sampled on the last clk cycle of q2 of each bit-8; a sampled 1 sets nack, which holds until the next accepted start or reset.
REQ-027 Without SCCB_ACK_CHECK_EN, nack SHALL be constant 0 and no siod sampling logic is built; timing is identical either way.

Verification (QTR=2 unless stated)
REQ-028 Reset, then start with id=0x42, reg_addr=0x12, value=0x80 -> sioc/siod decode to START, 0x42, Z, 0x12, Z, 0x80, Z, STOP; done exactly 233 cycles after the accept cycle.
REQ-029 Second start pulses while busy -> ignored; exactly one done; ready low for 232 cycles.
REQ-030 Start held high through done -> second transaction begins in the done cycle; two done pulses 233 cycles apart.
REQ-031 rst_n=0 at bit 10 -> next cycle sioc=1, siod=1, ready=1; no done pulse.
REQ-032 With SCCB_ACK_CHECK_EN, slave model pulls siod low on every bit 8 -> nack=0; leaves it floating-high on the phase-2 ACK -> nack=1 at done, cleared on next start.
REQ-033 QTR=1 -> done 117 cycles after accept; sioc high for exactly 2 cycles per data bit.
